// File: rtl/cic_interp_var_pkg.sv
// Shared constants and helpers for the variable-rate CIC interpolator.
// round_sat() backs the CIC_ROUND_SAT_EN output path.
package cic_interp_var_pkg;

  localparam int CIC_N_DEF      = 4;
  localparam int CIC_RL_MAX_DEF = 4;
  localparam int SAT_W          = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      res = res + (((32'sd1 <<< i) < value) ? 32'sd1 : 32'sd0);
    end
    return res;
  endfunction

  function automatic int cic_acc_w(input int in_w, input int n, input int rl_max);
    return in_w + n * rl_max;
  endfunction

  // Round half-up by 'shift' bits, then clamp to the signed out_w range.
  function automatic wide_t round_sat(input wide_t acc, input int shift, input int out_w);
    wide_t v;
    wide_t hi;
    wide_t lo;
    if (shift > 0) v = acc + (64'sd1 <<< (shift - 1));
    else v = acc;
    v  = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/cic_interp_var_integrator_chain.sv
// Pipelined integrator cascade: each stage accumulates the previous stage's registered value.
module cic_interp_var_integrator_chain #(
  parameter int N     = 4,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic signed [ACC_W-1:0] data_in,
  output logic signed [ACC_W-1:0] data_out
);

  logic signed [ACC_W-1:0] integ_r [N];

  // integrator registers, wrapping two's-complement accumulation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) integ_r[k] <= {ACC_W{1'b0}};
    end else if (enable) begin
      integ_r[0] <= integ_r[0] + data_in;
      for (int k = 1; k < N; k++) integ_r[k] <= integ_r[k] + integ_r[k-1];
    end
  end

  assign data_out = integ_r[N-1];

endmodule

// File: rtl/cic_interp_var.sv
// Order-N CIC interpolator with runtime power-of-two rate and unity-gain output.
// Define CIC_ROUND_SAT_EN for rounded/saturated output with one extra pipeline register.
module cic_interp_var
  import cic_interp_var_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int N      = CIC_N_DEF,
  parameter int RL_MAX = CIC_RL_MAX_DEF,
  parameter int ACC_W  = cic_acc_w(IN_W, N, RL_MAX),
  localparam int RLW   = clog2(RL_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_enable,
  input  logic [RLW-1:0]          rate_log2,
  input  logic signed [IN_W-1:0]  filter_in,
  output logic signed [OUT_W-1:0] filter_out,
  output logic                    ce_out,
  output logic [RLW-1:0]          rate_active
);

  localparam int PH_W = (RL_MAX > 0) ? RL_MAX : 1;

  logic [PH_W-1:0]         phase_r;
  logic [PH_W-1:0]         phase_max_s;
  logic                    phase_last_s;
  logic [RLW-1:0]          rate_active_r;
  logic [RLW-1:0]          rate_clamp_s;
  logic signed [ACC_W-1:0] comb_x_s [N+1];
  logic signed [ACC_W-1:0] comb_d_r [N];
  logic signed [ACC_W-1:0] integ_in_s;
  logic signed [ACC_W-1:0] integ_out_s;
  int                      shift_s;
  logic signed [OUT_W-1:0] scaled_s;
  logic signed [OUT_W-1:0] filter_out_r;
`ifdef CIC_ROUND_SAT_EN
  wide_t                   wide_s;
  logic signed [OUT_W-1:0] stage_r;
`else
  logic signed [ACC_W-1:0] trunc_s;
`endif

  // last phase of the rate in effect, and the clamped rate request
  always_comb begin
    phase_max_s  = ~({PH_W{1'b1}} << rate_active_r);
    phase_last_s = (phase_r == phase_max_s);
    if (rate_log2 > RLW'(RL_MAX)) rate_clamp_s = RLW'(RL_MAX);
    else rate_clamp_s = rate_log2;
  end

  assign ce_out      = reset_n & clk_enable & (phase_r == {PH_W{1'b0}});
  assign rate_active = rate_active_r;

  // phase counter; a new rate is only accepted at the wrap so R changes on a period boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r       <= {PH_W{1'b0}};
      rate_active_r <= {RLW{1'b0}};
    end else if (clk_enable) begin
      if (phase_last_s) begin
        phase_r       <= {PH_W{1'b0}};
        rate_active_r <= rate_clamp_s;
      end else begin
        phase_r <= phase_r + PH_W'(1'b1);
      end
    end
  end

  // comb cascade at input rate, then zero-stuffing into the integrators
  always_comb begin
    comb_x_s[0] = {{(ACC_W-IN_W){filter_in[IN_W-1]}}, filter_in};
    for (int k = 0; k < N; k++) comb_x_s[k+1] = comb_x_s[k] - comb_d_r[k];
    if (ce_out) integ_in_s = comb_x_s[N];
    else integ_in_s = {ACC_W{1'b0}};
  end

  // comb differential delays
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) comb_d_r[k] <= {ACC_W{1'b0}};
    end else if (ce_out) begin
      for (int k = 0; k < N; k++) comb_d_r[k] <= comb_x_s[k];
    end
  end

  cic_interp_var_integrator_chain #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_integ (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (clk_enable),
    .data_in  (integ_in_s),
    .data_out (integ_out_s)
  );

  // remove the R^(N-1) DC gain of the rate currently in effect
  always_comb begin
    shift_s = (N - 1) * int'(rate_active_r);
`ifdef CIC_ROUND_SAT_EN
    wide_s   = round_sat({{(SAT_W-ACC_W){integ_out_s[ACC_W-1]}}, integ_out_s}, shift_s, OUT_W);
    scaled_s = wide_s[OUT_W-1:0];
`else
    trunc_s  = integ_out_s >>> shift_s;
    scaled_s = trunc_s[OUT_W-1:0];
`endif
  end

`ifdef CIC_ROUND_SAT_EN
  // output pipeline: saturated stage then output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_r      <= {OUT_W{1'b0}};
      filter_out_r <= {OUT_W{1'b0}};
    end else if (clk_enable) begin
      stage_r      <= scaled_s;
      filter_out_r <= stage_r;
    end
  end
`else
  // output register, truncated value with wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filter_out_r <= {OUT_W{1'b0}};
    else if (clk_enable) filter_out_r <= scaled_s;
  end
`endif

  assign filter_out = filter_out_r;

endmodule
